// File: rtl/pipe_datapath.sv
// Two-stage ALU datapath: issue registers, then ALU result, status flags and register-file write.
// The stage-2 result is forwarded to the issuing operands so dependent back-to-back ops see fresh values.
module pipe_datapath #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          W_En,
  input  logic [AW-1:0] W_Adr,
  input  logic [AW-1:0] R_Adr,
  input  logic [AW-1:0] S_Adr,
  input  logic [3:0]    ALU_OP,
  input  logic          S_Sel,
  input  logic [DW-1:0] DS,
  output logic          out_valid,
  output logic [DW-1:0] Alu_Out,
  output logic [DW-1:0] Reg_Out,
  output logic          N,
  output logic          Z,
  output logic          C
);

  localparam int NREG = 2**AW;

  logic [DW-1:0] r_rf [NREG];
  logic          r_s1_valid;
  logic          r_s1_wen;
  logic [AW-1:0] r_s1_wadr;
  logic [3:0]    r_s1_op;
  logic [DW-1:0] r_s1_r;
  logic [DW-1:0] r_s1_s;

  logic [DW-1:0] w_res;
  logic          w_c;
  logic [DW:0]   w_sum;
  logic          w_fwd_r;
  logic          w_fwd_s;
  logic [DW-1:0] w_opr;
  logic [DW-1:0] w_ops;

  // The op in stage 1 writes the file on the same edge the next op issues, so bypass the file.
  assign w_fwd_r = r_s1_valid && r_s1_wen && (r_s1_wadr == R_Adr);
  assign w_fwd_s = r_s1_valid && r_s1_wen && (r_s1_wadr == S_Adr);
  assign w_opr   = w_fwd_r ? w_res : r_rf[R_Adr];
  assign w_ops   = S_Sel ? DS : (w_fwd_s ? w_res : r_rf[S_Adr]);

  always_comb begin
    w_res = r_s1_r;
    w_c   = 1'b0;
    w_sum = '0;
    case (r_s1_op)
      4'h1: w_res = r_s1_s;
      4'h2: begin
        w_sum = {1'b0, r_s1_r} + {1'b0, r_s1_s};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
      end
      4'h3: begin
        w_sum = {1'b0, r_s1_r} - {1'b0, r_s1_s};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
      end
      4'h4: begin
        w_sum = {1'b0, r_s1_r} + {{DW{1'b0}}, 1'b1};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
      end
      4'h5: begin
        w_sum = {1'b0, r_s1_r} - {{DW{1'b0}}, 1'b1};
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
      end
      4'h6: w_res = r_s1_r & r_s1_s;
      4'h7: w_res = r_s1_r | r_s1_s;
      4'h8: w_res = r_s1_r ^ r_s1_s;
      4'h9: w_res = ~r_s1_r;
      4'hA: begin
        w_res = {r_s1_r[DW-2:0], 1'b0};
        w_c   = r_s1_r[DW-1];
      end
      4'hB: begin
        w_res = {1'b0, r_s1_r[DW-1:1]};
        w_c   = r_s1_r[0];
      end
      4'hC: begin
        w_res = {r_s1_r[DW-1], r_s1_r[DW-1:1]};
        w_c   = r_s1_r[0];
      end
      default: w_res = r_s1_r;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_wen   <= 1'b0;
      r_s1_wadr  <= '0;
      r_s1_op    <= '0;
      r_s1_r     <= '0;
      r_s1_s     <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_wen  <= W_En;
        r_s1_wadr <= W_Adr;
        r_s1_op   <= ALU_OP;
        r_s1_r    <= w_opr;
        r_s1_s    <= w_ops;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      Alu_Out   <= '0;
      Reg_Out   <= '0;
      N         <= 1'b0;
      Z         <= 1'b1;
      C         <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        Alu_Out <= w_res;
        Reg_Out <= r_s1_r;
        N       <= w_res[DW-1];
        Z       <= (w_res == '0);
        C       <= w_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_s1_valid && r_s1_wen) begin
      r_rf[r_s1_wadr] <= w_res;
    end
  end

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: an architectural model (register file updated at issue) checked every cycle,
// plus literal expectations for the key scenarios and a DW=8/AW=4 instance.
module tb_pipe_datapath;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          W_En = 1'b0;
  logic          S_Sel = 1'b0;
  logic [AW-1:0] W_Adr = '0, R_Adr = '0, S_Adr = '0;
  logic [3:0]    ALU_OP = '0;
  logic [DW-1:0] DS = '0;
  logic          out_valid, N, Z, C;
  logic [DW-1:0] Alu_Out, Reg_Out;

  logic       b_in_valid = 1'b0, b_W_En = 1'b0, b_S_Sel = 1'b0;
  logic [3:0] b_W_Adr = '0, b_R_Adr = '0, b_S_Adr = '0, b_ALU_OP = '0;
  logic [7:0] b_DS = '0;
  logic       b_out_valid, b_N, b_Z, b_C;
  logic [7:0] b_Alu_Out, b_Reg_Out;

  always #5 clk = ~clk;

  pipe_datapath #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .W_En(W_En),
    .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .ALU_OP(ALU_OP),
    .S_Sel(S_Sel), .DS(DS), .out_valid(out_valid), .Alu_Out(Alu_Out),
    .Reg_Out(Reg_Out), .N(N), .Z(Z), .C(C)
  );

  pipe_datapath #(.DW(8), .AW(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .W_En(b_W_En),
    .W_Adr(b_W_Adr), .R_Adr(b_R_Adr), .S_Adr(b_S_Adr), .ALU_OP(b_ALU_OP),
    .S_Sel(b_S_Sel), .DS(b_DS), .out_valid(b_out_valid), .Alu_Out(b_Alu_Out),
    .Reg_Out(b_Reg_Out), .N(b_N), .Z(b_Z), .C(b_C)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain unsigned arithmetic; returns {carry, result}.
  function automatic logic [DW:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] r,
                                          input logic [DW-1:0] s);
    longint unsigned ur, us, m, top, y;
    bit c;
    ur = r; us = s;
    m = (64'd1 << DW) - 1;
    top = 64'd1 << (DW - 1);
    c = 1'b0;
    case (op)
      4'd1: y = us;
      4'd2: begin y = ur + us; c = (y > m); end
      4'd3: begin y = ur - us; c = (ur < us); end
      4'd4: begin y = ur + 1; c = (y > m); end
      4'd5: begin y = ur - 1; c = (ur == 0); end
      4'd6: y = ur & us;
      4'd7: y = ur | us;
      4'd8: y = ur ^ us;
      4'd9: y = ~ur;
      4'd10: begin y = ur * 2; c = (ur >= top); end
      4'd11: begin y = ur / 2; c = (ur % 2) != 0; end
      4'd12: begin y = ur / 2 + ((ur >= top) ? top : 0); c = (ur % 2) != 0; end
      default: y = ur;
    endcase
    y = y & m;
    return {c, y[DW-1:0]};
  endfunction

  // Architectural model: forwarding makes every op see all earlier writes, so write at issue.
  logic [DW-1:0] m_rf [2**AW];
  logic          p_valid = 1'b0, p_c = 1'b0;
  logic [DW-1:0] p_res = '0, p_r = '0, m_s;
  logic [DW:0]   m_o;
  logic          e_valid = 1'b0, e_n = 1'b0, e_z = 1'b1, e_c = 1'b0;
  logic [DW-1:0] e_alu = '0, e_reg = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 2**AW; i++) m_rf[i] = '0;
        p_valid = 1'b0;
        e_valid = 1'b0; e_alu = '0; e_reg = '0;
        e_n = 1'b0; e_z = 1'b1; e_c = 1'b0;
      end else begin
        e_valid = p_valid;
        if (p_valid) begin
          e_alu = p_res; e_reg = p_r;
          e_n = p_res[DW-1]; e_z = (p_res == 0); e_c = p_c;
        end
        p_valid = in_valid;
        if (in_valid) begin
          p_r = m_rf[R_Adr];
          m_s = S_Sel ? DS : m_rf[S_Adr];
          m_o = ref_alu(ALU_OP, p_r, m_s);
          p_res = m_o[DW-1:0];
          p_c = m_o[DW];
          if (W_En) m_rf[W_Adr] = p_res;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_out_valid", out_valid, e_valid);
      chk("cmp_alu_out", Alu_Out, e_alu);
      chk("cmp_reg_out", Reg_Out, e_reg);
      chk("cmp_nzc", {N, Z, C}, {e_n, e_z, e_c});
    end
  end

  task automatic issue(input logic [3:0] op, input int ra, input int sa, input int wa,
                       input bit wen, input bit ssel, input logic [DW-1:0] ds);
    in_valid = 1'b1; ALU_OP = op;
    R_Adr = ra[AW-1:0]; S_Adr = sa[AW-1:0]; W_Adr = wa[AW-1:0];
    W_En = wen; S_Sel = ssel; DS = ds;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; W_En = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_out", Alu_Out, 16'h0);
    chk("rst_reg_out", Reg_Out, 16'h0);
    chk("rst_nzc", {N, Z, C}, 3'b010);

    // Release reset and issue on the very first edge after release.
    reset = 1'b0;
    issue(4'h1, 0, 0, 1, 1, 1, 16'h1234);
    idle();
    chk("first_valid", out_valid, 1'b1);
    chk("first_alu", Alu_Out, 16'h1234);
    chk("first_nzc", {N, Z, C}, 3'b000);
    issue(4'h0, 1, 0, 0, 0, 0, 16'h0);
    idle();
    chk("first_reg1", Alu_Out, 16'h1234);

    // Back-to-back dependency through forwarding.
    issue(4'h1, 0, 0, 1, 1, 1, 16'hFFFF);
    issue(4'h4, 1, 0, 1, 1, 0, 16'h0);
    issue(4'h0, 1, 0, 0, 0, 0, 16'h0);
    chk("dep_inc_alu", Alu_Out, 16'h0000);
    chk("dep_inc_nzc", {N, Z, C}, 3'b011);
    idle();
    chk("dep_fwd_alu", Alu_Out, 16'h0000);

    issue(4'h1, 0, 0, 2, 1, 1, 16'h0003);
    issue(4'h1, 0, 0, 3, 1, 1, 16'h0005);
    issue(4'h3, 2, 3, 7, 1, 0, 16'h0);
    idle();
    chk("sub_alu", Alu_Out, 16'hFFFE);
    chk("sub_nzc", {N, Z, C}, 3'b101);
    issue(4'h1, 0, 0, 4, 1, 1, 16'h8001);
    issue(4'hC, 4, 0, 0, 0, 0, 16'h0);
    idle();
    chk("asr_alu", Alu_Out, 16'hC000);
    chk("asr_nzc", {N, Z, C}, 3'b101);

    // Both sources forwarded from the same in-flight write.
    issue(4'h1, 0, 0, 5, 1, 1, 16'h0102);
    issue(4'h2, 5, 5, 5, 1, 0, 16'h0);
    idle();
    chk("both_fwd_alu", Alu_Out, 16'h0204);

    issue(4'h1, 0, 0, 2, 1, 1, 16'hA5C3);
    issue(4'h1, 0, 0, 3, 1, 1, 16'h0F0F);
    for (int op = 0; op < 16; op++) issue(op[3:0], 2, 3, 6, 0, 0, 16'h0);
    idle();
    chk("sweep_last_reg", Reg_Out, 16'hA5C3);

    // Idle gap: outputs and flags hold.
    issue(4'h1, 0, 0, 0, 0, 1, 16'h8000);
    idle();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("gap_valid", out_valid, 1'b0);
      chk("gap_alu", Alu_Out, 16'h8000);
      chk("gap_nzc", {N, Z, C}, 3'b100);
    end

    // Reset between issue and completion discards the op.
    issue(4'h1, 0, 0, 6, 1, 1, 16'hBEEF);
    #2;
    reset = 1'b1; in_valid = 1'b0; W_En = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    reset = 1'b0;
    idle();
    chk("post_rst_valid", out_valid, 1'b0);
    for (int i = 0; i < 8; i++) issue(4'h0, i, 0, 0, 0, 0, 16'h0);
    issue(4'h9, 6, 0, 0, 0, 0, 16'h0);
    idle();
    chk("post_rst_not_reg6", Alu_Out, 16'hFFFF);

    // DW=8, AW=4 instance.
    b_in_valid = 1'b1; b_ALU_OP = 4'h1; b_W_Adr = 4'd15; b_W_En = 1'b1;
    b_S_Sel = 1'b1; b_DS = 8'h7F;
    @(negedge clk);
    b_ALU_OP = 4'h2; b_R_Adr = 4'd15; b_W_En = 1'b0; b_S_Sel = 1'b1; b_DS = 8'h01;
    @(negedge clk);
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_valid", b_out_valid, 1'b1);
    chk("b_alu", b_Alu_Out, 8'h80);
    chk("b_reg", b_Reg_Out, 8'h7F);
    chk("b_nzc", {b_N, b_Z, b_C}, 3'b100);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter DW, default 16, data width in bits (legal values 4..64).
REQ-002 Parameter AW, default 3, register address width; the register file holds 2**AW registers of DW bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 in_valid  input  1  issue strobe; operation fields are sampled on the clk edge when it is 1.
REQ-006 W_En  input  1  write-back enable for the issued operation.
REQ-007 W_Adr, R_Adr, S_Adr  input  AW each  destination, R-source and S-source register addresses.
REQ-008 ALU_OP  input  4  operation code; encoding defined in REQ-014.
REQ-009 S_Sel  input  1  operand select: 1 selects DS, 0 selects register S.
REQ-010 DS  input  DW  direct (immediate) operand.
REQ-011 out_valid  output  1  one-cycle strobe marking a completed operation.
REQ-012 Alu_Out, Reg_Out  output  DW each  registered ALU result and registered forwarded R operand of the completed operation.
REQ-013 N, Z, C  output  1 each  registered status flags.

Function
REQ-014 ALU_OP encoding: 0 pass R; 1 pass S; 2 R+S; 3 R-S; 4 R+1; 5 R-1; 6 AND; 7 OR; 8 XOR; 9 NOT R; A R<<1; B R>>1 logical; C R>>1 arithmetic; D-F pass R.
REQ-015 Stage 1 (issue edge): when in_valid=1, capture R operand, S operand (S_Sel ? DS : S), ALU_OP, W_Adr and W_En into pipeline registers, and set s1_valid; when in_valid=0, clear s1_valid.
REQ-016 Stage 2 (next edge): when s1_valid=1, compute the result combinationally from the stage-1 registers; load it into Alu_Out, load the R operand into Reg_Out, pulse out_valid=1 for one cycle, and write the register file if W_En=1.
REQ-017 Latency: an operation issued at edge k produces out_valid, Alu_Out and the register write at edge k+1, with outputs visible during cycle k+1.
REQ-018 Throughput: one operation per cycle; there is no stall and no back-pressure.
REQ-019 Forwarding: when stage 2 holds a valid operation with W_En=1 whose W_Adr equals the issuing R_Adr (or S_Adr with S_Sel=0), the issuing operand takes the stage-2 result instead of the register-file value.
REQ-020 The register file is read asynchronously and written synchronously.
REQ-021 When both sources match the forwarded address, both are forwarded.
REQ-022 Arithmetic is modulo 2**DW.
REQ-023 N = result[DW-1] and Z = (result==0).
REQ-024 C rules:
- ops 2 and 4: carry-out;
- ops 3 and 5: borrow (op 3: R<S unsigned; op 5: R==0);
- op A: R[DW-1];
- ops B and C: R[0];
- all other ops: 0.
REQ-025 N, Z and C update only on edges where out_valid is asserted; otherwise they hold.
REQ-026 Alu_Out and Reg_Out hold their last values when out_valid=0.
REQ-027 Write to the register being read in the same cycle: the issuing operand gets the forwarded new value (REQ-019), never the stale value.

Reset
REQ-028 While reset=1, independent of clk:
- all 2**AW registers are 0;
- s1_valid=0 and out_valid=0;
- Alu_Out=0 and Reg_Out=0;
- N=0, Z=1, C=0.
REQ-029 Reset asserted mid-operation discards in-flight operations with no register write; after release, the first issue produces out_valid on the edge after its issue edge.
REQ-030 in_valid sampled on the first edge after reset deasserts is honoured.

Verification
REQ-031 Reset, then issue op 1 with S_Sel=1, DS=0x1234, W_Adr=1, W_En=1 -> out_valid one cycle after issue, Alu_Out=0x1234, N=0, Z=0, C=0, and reg1=0x1234.
REQ-032 Back-to-back dependency (DW=16):
- stimulus: reg1=0xFFFF; cycle k issue op 4 (R_Adr=1, W_Adr=1); cycle k+1 issue op 0 (R_Adr=1);
- required response: second Alu_Out=0x0000 (forwarded), first result 0x0000 with C=1 and Z=1.
REQ-033 Op 3 with R=0x0003 and S=0x0005 -> Alu_Out=0xFFFE, N=1, C=1; op C with R=0x8001 -> Alu_Out=0xC000, C=1.
REQ-034 Idle gap: after a result, hold in_valid=0 for 3 cycles -> out_valid=0 and Alu_Out, N, Z, C unchanged.
REQ-035 Reset pulse between issue and completion -> no out_valid and no register write; all registers read 0 afterwards.
REQ-036 Parameter sweep DW=8, AW=4: write reg15=0x7F, then op 2 with S_Sel=1, DS=0x01 -> Alu_Out=0x80, N=1, C=0.
